// File: rtl/ibex_multdiv_iter_if.sv
// Request/response bundle for the iterative multiply/divide unit.
// The master side issues operations; the slave side is the unit itself.
interface ibex_multdiv_iter_if #(
  parameter int unsigned Width = 32
);
  logic             en_i;
  logic             kill_i;
  logic [1:0]       operator_i;
  logic [1:0]       signed_mode_i;
  logic [Width-1:0] op_a_i;
  logic [Width-1:0] op_b_i;
  logic             data_ind_timing_i;
  logic             ready_o;
  logic             busy_o;
  logic             valid_o;
  logic [Width-1:0] result_o;

  modport master (
    output en_i, kill_i, operator_i, signed_mode_i, op_a_i, op_b_i, data_ind_timing_i,
    input  ready_o, busy_o, valid_o, result_o
  );

  modport slave (
    input  en_i, kill_i, operator_i, signed_mode_i, op_a_i, op_b_i, data_ind_timing_i,
    output ready_o, busy_o, valid_o, result_o
  );
endinterface

// File: rtl/ibex_multdiv_iter.sv
// Iterative RV32M multiply/divide: radix-2^BitsPerCycle shift-add multiply and
// restoring divide on operand magnitudes, with sign fix-up on the last cycle.
module ibex_multdiv_iter #(
  parameter int unsigned Width        = 32,
  parameter int unsigned BitsPerCycle = 1,
  parameter bit          EarlyOut     = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  ibex_multdiv_iter_if.slave bus
);
  localparam int unsigned N    = Width / BitsPerCycle;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] OpMul  = 2'd0;
  localparam logic [1:0] OpMulh = 2'd1;
  localparam logic [1:0] OpDiv  = 2'd2;

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2*Width-1:0] acc_q, acc_d;
  logic [Width-1:0]   opa_q, opa_d, opb_q, opb_d;
  logic [Width-1:0]   result_q, result_d;
  logic [1:0]         oper_q, oper_d;
  logic               neg_q, neg_d;

  logic               ready, accept, early, sa, sb;
  logic [2*Width-1:0] mul_acc, prod;
  logic [Width-1:0]   mul_opb, div_opa;
  logic [Width-1:0]   rem, quo;
  logic [Width:0]     trial;
  logic [Width+BitsPerCycle-1:0] pp, sum;

  function automatic logic [Width-1:0] cond_neg(input logic [Width-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  assign ready        = ((state_q == IDLE) || (state_q == FINISH)) & ~bus.kill_i;
  assign accept       = bus.en_i & ready;
  assign bus.ready_o  = ready;
  assign bus.busy_o   = (state_q == CALC);
  assign bus.valid_o  = (state_q == FINISH);
  assign bus.result_o = result_q;

  // One iteration of each datapath, evaluated from the current state.
  always_comb begin
    pp = '0;
    for (int i = 0; i < BitsPerCycle; i++) begin
      if (opb_q[i]) pp = pp + ({{BitsPerCycle{1'b0}}, opa_q} << i);
    end
    sum     = {{BitsPerCycle{1'b0}}, acc_q[2*Width-1:Width]} + pp;
    mul_acc = {sum, acc_q[Width-1:BitsPerCycle]};
    mul_opb = opb_q >> BitsPerCycle;

    rem     = acc_q[2*Width-1:Width];
    quo     = acc_q[Width-1:0];
    div_opa = opa_q;
    trial   = '0;
    for (int i = 0; i < BitsPerCycle; i++) begin
      trial   = {rem, div_opa[Width-1]};
      div_opa = div_opa << 1;
      if (trial >= {1'b0, opb_q}) begin
        trial = trial - {1'b0, opb_q};
        quo   = {quo[Width-2:0], 1'b1};
      end else begin
        quo   = {quo[Width-2:0], 1'b0};
      end
      rem = trial[Width-1:0];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    oper_d   = oper_q;
    neg_d    = neg_q;
    result_d = result_q;
    prod     = '0;
    sa       = bus.signed_mode_i[0] & bus.op_a_i[Width-1];
    sb       = bus.signed_mode_i[1] & bus.op_b_i[Width-1];
    early    = EarlyOut && !bus.data_ind_timing_i && bus.operator_i[1] && (bus.op_b_i == '0);

    if (bus.kill_i) begin
      state_d = IDLE;
    end else if (accept) begin
      oper_d = bus.operator_i;
      opa_d  = cond_neg(bus.op_a_i, sa);
      opb_d  = cond_neg(bus.op_b_i, sb);
      acc_d  = '0;
      cnt_d  = CntW'(N - 1);
      // A zero divisor keeps the all-ones quotient unsigned; REM follows the dividend.
      case (bus.operator_i)
        OpMul, OpMulh: neg_d = sa ^ sb;
        OpDiv:         neg_d = (sa ^ sb) & (bus.op_b_i != '0);
        default:       neg_d = sa;
      endcase
      if (early) begin
        state_d  = FINISH;
        result_d = (bus.operator_i == OpDiv) ? '1 : bus.op_a_i;
      end else begin
        state_d = CALC;
      end
    end else begin
      case (state_q)
        CALC: begin
          if (oper_q[1]) begin
            acc_d = {rem, quo};
            opa_d = div_opa;
          end else begin
            acc_d = mul_acc;
            opb_d = mul_opb;
          end
          if (cnt_q == '0) begin
            state_d = FINISH;
            prod    = neg_q ? -acc_d : acc_d;
            case (oper_q)
              OpMul:   result_d = prod[Width-1:0];
              OpMulh:  result_d = prod[2*Width-1:Width];
              OpDiv:   result_d = cond_neg(acc_d[Width-1:0], neg_q);
              default: result_d = cond_neg(acc_d[2*Width-1:Width], neg_q);
            endcase
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
        FINISH:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      oper_q   <= '0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      oper_q   <= oper_d;
      neg_q    <= neg_d;
    end
  end

  // Operand magnitudes are pure data and are always reloaded on accept.
  always_ff @(posedge clk_i) begin
    opa_q <= opa_d;
    opb_q <= opb_d;
  end
endmodule

// File: tb/tb_ibex_multdiv_iter.sv
// Directed bench for ibex_multdiv_iter: radix 4 main instance plus radix 2 and
// radix 16 instances for the latency sweep.
module tb_ibex_multdiv_iter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [2:0]  en_v;
  logic        kill;
  logic [1:0]  oper, sm;
  logic [31:0] opa, opb;
  logic        dit;

  int n_chk  = 0;
  int n_fail = 0;

  ibex_multdiv_iter_if #(.Width(32)) b0 ();
  ibex_multdiv_iter_if #(.Width(32)) b1 ();
  ibex_multdiv_iter_if #(.Width(32)) b2 ();

  assign b0.en_i = en_v[0];
  assign b1.en_i = en_v[1];
  assign b2.en_i = en_v[2];
  assign b0.kill_i = kill;             assign b1.kill_i = kill;             assign b2.kill_i = kill;
  assign b0.operator_i = oper;         assign b1.operator_i = oper;         assign b2.operator_i = oper;
  assign b0.signed_mode_i = sm;        assign b1.signed_mode_i = sm;        assign b2.signed_mode_i = sm;
  assign b0.op_a_i = opa;              assign b1.op_a_i = opa;              assign b2.op_a_i = opa;
  assign b0.op_b_i = opb;              assign b1.op_b_i = opb;              assign b2.op_b_i = opb;
  assign b0.data_ind_timing_i = dit;   assign b1.data_ind_timing_i = dit;   assign b2.data_ind_timing_i = dit;

  ibex_multdiv_iter #(.Width(32), .BitsPerCycle(2), .EarlyOut(1'b1)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .bus(b0));
  ibex_multdiv_iter #(.Width(32), .BitsPerCycle(1), .EarlyOut(1'b1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .bus(b1));
  ibex_multdiv_iter #(.Width(32), .BitsPerCycle(4), .EarlyOut(1'b1)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .bus(b2));

  function automatic logic get_valid(input int w);
    case (w)
      0:       return b0.valid_o;
      1:       return b1.valid_o;
      default: return b2.valid_o;
    endcase
  endfunction

  function automatic logic [31:0] get_result(input int w);
    case (w)
      0:       return b0.result_o;
      1:       return b1.result_o;
      default: return b2.result_o;
    endcase
  endfunction

  // Called at a negedge; issues one op and returns at the negedge of the valid cycle.
  task automatic run_op(input int w, input logic [1:0] op, input logic [1:0] s,
                        input logic [31:0] a, input logic [31:0] b, input logic d,
                        output logic [31:0] res, output int lat);
    oper = op; sm = s; opa = a; opb = b; dit = d;
    en_v[w] = 1'b1;
    @(posedge clk); #1;
    en_v = '0;
    opa = ~a; opb = b ^ 32'h5; oper = ~op; sm = ~s; dit = ~d;
    lat = -1;
    res = 'x;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (get_valid(w)) begin
        lat = c;
        res = get_result(w);
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en_v = '0; kill = 1'b0; oper = '0; sm = '0; opa = '0; opb = '0; dit = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++; if (b0.ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", b0.ready_o); end
    n_chk++; if (b0.busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", b0.busy_o); end
    n_chk++; if (b0.valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", b0.valid_o); end
    n_chk++; if (b0.result_o !== 32'h0) begin n_fail++; $display("FAIL reset_result got %h exp 0", b0.result_o); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mul();
    logic [31:0] r; int l;
    run_op(0, 2'd0, 2'd3, 32'd7, 32'hFFFFFFFD, 1'b0, r, l);
    n_chk++; if (r !== 32'hFFFFFFEB) begin n_fail++; $display("FAIL mul_signed got %h exp ffffffeb", r); end
    n_chk++; if (l !== 17) begin n_fail++; $display("FAIL mul_latency got %0d exp 17", l); end
    n_chk++; if (b0.ready_o !== 1'b1) begin n_fail++; $display("FAIL finish_ready got %b exp 1", b0.ready_o); end
    run_op(0, 2'd1, 2'd3, 32'h80000000, 32'h80000000, 1'b0, r, l);
    n_chk++; if (r !== 32'h40000000) begin n_fail++; $display("FAIL mulh got %h exp 40000000", r); end
    run_op(0, 2'd1, 2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, r, l);
    n_chk++; if (r !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL mulhu got %h exp fffffffe", r); end
    run_op(0, 2'd1, 2'd1, 32'hFFFFFFFF, 32'd2, 1'b0, r, l);
    n_chk++; if (r !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mulhsu got %h exp ffffffff", r); end
  endtask

  task automatic test_div();
    logic [31:0] r; int l;
    run_op(0, 2'd2, 2'd3, 32'hFFFFFFF9, 32'd2, 1'b0, r, l);
    n_chk++; if (r !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL div_signed got %h exp fffffffd", r); end
    n_chk++; if (l !== 17) begin n_fail++; $display("FAIL div_latency got %0d exp 17", l); end
    run_op(0, 2'd3, 2'd3, 32'hFFFFFFF9, 32'd2, 1'b0, r, l);
    n_chk++; if (r !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL rem_signed got %h exp ffffffff", r); end
    run_op(0, 2'd2, 2'd0, 32'd100, 32'd7, 1'b0, r, l);
    n_chk++; if (r !== 32'd14) begin n_fail++; $display("FAIL divu got %h exp 0000000e", r); end
    run_op(0, 2'd3, 2'd0, 32'd100, 32'd7, 1'b0, r, l);
    n_chk++; if (r !== 32'd2) begin n_fail++; $display("FAIL remu got %h exp 00000002", r); end
    run_op(0, 2'd2, 2'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, r, l);
    n_chk++; if (r !== 32'h80000000) begin n_fail++; $display("FAIL div_overflow got %h exp 80000000", r); end
    run_op(0, 2'd3, 2'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, r, l);
    n_chk++; if (r !== 32'h0) begin n_fail++; $display("FAIL rem_overflow got %h exp 0", r); end
  endtask

  task automatic test_div_zero();
    logic [31:0] r; int l;
    run_op(0, 2'd2, 2'd3, 32'd100, 32'd0, 1'b0, r, l);
    n_chk++; if (r !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL divz_early got %h exp ffffffff", r); end
    n_chk++; if (l !== 1) begin n_fail++; $display("FAIL divz_early_lat got %0d exp 1", l); end
    run_op(0, 2'd3, 2'd3, 32'd100, 32'd0, 1'b0, r, l);
    n_chk++; if (r !== 32'd100) begin n_fail++; $display("FAIL remz_early got %h exp 00000064", r); end
    n_chk++; if (l !== 1) begin n_fail++; $display("FAIL remz_early_lat got %0d exp 1", l); end
    run_op(0, 2'd2, 2'd3, 32'd100, 32'd0, 1'b1, r, l);
    n_chk++; if (r !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL divz_const got %h exp ffffffff", r); end
    n_chk++; if (l !== 17) begin n_fail++; $display("FAIL divz_const_lat got %0d exp 17", l); end
    run_op(0, 2'd3, 2'd3, 32'd100, 32'd0, 1'b1, r, l);
    n_chk++; if (r !== 32'd100) begin n_fail++; $display("FAIL remz_const got %h exp 00000064", r); end
    n_chk++; if (l !== 17) begin n_fail++; $display("FAIL remz_const_lat got %0d exp 17", l); end
    run_op(0, 2'd2, 2'd3, 32'hFFFFFFF9, 32'd0, 1'b1, r, l);
    n_chk++; if (r !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL divz_neg got %h exp ffffffff", r); end
    run_op(0, 2'd3, 2'd3, 32'hFFFFFFF9, 32'd0, 1'b1, r, l);
    n_chk++; if (r !== 32'hFFFFFFF9) begin n_fail++; $display("FAIL remz_neg got %h exp fffffff9", r); end
  endtask

  task automatic test_kill();
    logic [31:0] r; int l; int pulses;
    run_op(0, 2'd0, 2'd0, 32'd3, 32'd4, 1'b0, r, l);
    n_chk++; if (r !== 32'd12) begin n_fail++; $display("FAIL kill_pre got %h exp 0000000c", r); end
    oper = 2'd0; sm = 2'd0; opa = 32'd5; opb = 32'd6; dit = 1'b0; en_v[0] = 1'b1;
    @(posedge clk); #1; en_v = '0;
    repeat (5) @(negedge clk);
    kill = 1'b1; #1;
    n_chk++; if (b0.ready_o !== 1'b0) begin n_fail++; $display("FAIL kill_ready_low got %b exp 0", b0.ready_o); end
    n_chk++; if (b0.busy_o !== 1'b1) begin n_fail++; $display("FAIL kill_busy got %b exp 1", b0.busy_o); end
    @(posedge clk); #1; kill = 1'b0;
    @(negedge clk);
    n_chk++; if (b0.ready_o !== 1'b1) begin n_fail++; $display("FAIL kill_ready_after got %b exp 1", b0.ready_o); end
    n_chk++; if (b0.busy_o !== 1'b0) begin n_fail++; $display("FAIL kill_busy_after got %b exp 0", b0.busy_o); end
    n_chk++; if (b0.result_o !== 32'd12) begin n_fail++; $display("FAIL kill_result got %h exp 0000000c", b0.result_o); end
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      if (b0.valid_o) pulses++;
      @(negedge clk);
    end
    n_chk++; if (pulses !== 0) begin n_fail++; $display("FAIL kill_no_valid got %0d pulses exp 0", pulses); end
  endtask

  task automatic test_en_kill();
    oper = 2'd2; sm = 2'd0; opa = 32'd100; opb = 32'd0; dit = 1'b0;
    en_v[0] = 1'b1; kill = 1'b1; #1;
    n_chk++; if (b0.ready_o !== 1'b0) begin n_fail++; $display("FAIL enkill_ready got %b exp 0", b0.ready_o); end
    @(posedge clk); #1; en_v = '0; kill = 1'b0;
    @(negedge clk);
    n_chk++; if (b0.valid_o !== 1'b0) begin n_fail++; $display("FAIL enkill_valid got %b exp 0", b0.valid_o); end
    n_chk++; if (b0.result_o !== 32'd12) begin n_fail++; $display("FAIL enkill_result got %h exp 0000000c", b0.result_o); end
    oper = 2'd0; opb = 32'd3; en_v[0] = 1'b1; kill = 1'b1;
    @(posedge clk); #1; en_v = '0; kill = 1'b0;
    @(negedge clk);
    n_chk++; if (b0.busy_o !== 1'b0) begin n_fail++; $display("FAIL enkill_busy got %b exp 0", b0.busy_o); end
  endtask

  task automatic test_reset_mid();
    oper = 2'd0; sm = 2'd0; opa = 32'd9; opb = 32'd9; dit = 1'b0; en_v[0] = 1'b1;
    @(posedge clk); #1; en_v = '0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0; #1;
    n_chk++; if (b0.ready_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready got %b exp 1", b0.ready_o); end
    n_chk++; if (b0.busy_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b exp 0", b0.busy_o); end
    n_chk++; if (b0.valid_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid got %b exp 0", b0.valid_o); end
    n_chk++; if (b0.result_o !== 32'h0) begin n_fail++; $display("FAIL rstmid_result got %h exp 0", b0.result_o); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] r; int l; int tot;
    logic [1:0]  sms [4] = '{2'd0, 2'd0, 2'd0, 2'd3};
    logic [31:0] as  [4] = '{32'd3, 32'h00010000, 32'hFFFFFFFF, 32'hFFFFFFFE};
    logic [31:0] bs  [4] = '{32'd5, 32'h00010000, 32'hFFFFFFFF, 32'hFFFFFFFD};
    logic [31:0] exp [4] = '{32'd15, 32'h0, 32'd1, 32'd6};
    tot = 0;
    for (int k = 0; k < 4; k++) begin
      run_op(0, 2'd0, sms[k], as[k], bs[k], 1'b0, r, l);
      tot += l;
      n_chk++; if (r !== exp[k]) begin n_fail++; $display("FAIL b2b_result%0d got %h exp %h", k, r, exp[k]); end
      n_chk++; if (tot !== 17 * (k + 1)) begin n_fail++; $display("FAIL b2b_cycle%0d got %0d exp %0d", k, tot, 17 * (k + 1)); end
    end
  endtask

  task automatic test_sweep();
    logic [31:0] r; int l;
    run_op(1, 2'd0, 2'd3, 32'd7, 32'hFFFFFFFD, 1'b0, r, l);
    n_chk++; if (r !== 32'hFFFFFFEB) begin n_fail++; $display("FAIL r2_mul got %h exp ffffffeb", r); end
    n_chk++; if (l !== 33) begin n_fail++; $display("FAIL r2_latency got %0d exp 33", l); end
    run_op(1, 2'd3, 2'd0, 32'd100, 32'd7, 1'b0, r, l);
    n_chk++; if (r !== 32'd2) begin n_fail++; $display("FAIL r2_remu got %h exp 00000002", r); end
    run_op(2, 2'd0, 2'd3, 32'd7, 32'hFFFFFFFD, 1'b0, r, l);
    n_chk++; if (r !== 32'hFFFFFFEB) begin n_fail++; $display("FAIL r16_mul got %h exp ffffffeb", r); end
    n_chk++; if (l !== 9) begin n_fail++; $display("FAIL r16_latency got %0d exp 9", l); end
    run_op(2, 2'd2, 2'd3, 32'hFFFFFFF9, 32'd2, 1'b0, r, l);
    n_chk++; if (r !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL r16_div got %h exp fffffffd", r); end
    run_op(2, 2'd1, 2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, r, l);
    n_chk++; if (r !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL r16_mulhu got %h exp fffffffe", r); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_zero();
    test_kill();
    test_en_kill();
    test_reset_mid();
    test_back_to_back();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ibex_multdiv_iter.md
# ibex_multdiv_iter

Parametrised iterative multiply/divide unit for the Ibex execute stage. It completes RV32M MUL/MULH[SU|U]/DIV[U]/REM[U] with a configurable radix (BitsPerCycle) and operand width. Operand, accumulator and counter state are held internally instead of in the ID-stage intermediate-value registers. It sits beside `ibex_alu` in the execute block, is selected when mult/div is selected, and adds abort, early-out and back-to-back issue.

## Interface
Parameters:
- Width, 32: operand/result width; power of two, 8..64.
- BitsPerCycle, 1: product/quotient bits resolved per CALC cycle; 1, 2 or 4; must divide Width.
- EarlyOut, 1: enables the divide-by-zero shortcut.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset, asynchronous and active-low.
- en_i  in  1  start request; accepted when en_i & ready_o.
- kill_i  in  1  abort the current operation; wins over en_i.
- operator_i  in  2  0 MUL, 1 MULH, 2 DIV, 3 REM.
- signed_mode_i  in  2  bit0: op_a signed; bit1: op_b signed.
- op_a_i  in  Width  multiplicand/dividend.
- op_b_i  in  Width  multiplier/divisor.
- data_ind_timing_i  in  1  1 disables the early-out; latency is constant.
- ready_o  out  1  can accept a new operation.
- busy_o  out  1  state is CALC.
- valid_o  out  1  one-cycle pulse; result_o is valid.
- result_o  out  Width  registered result.

## Operation
- N = Width/BitsPerCycle.
- States:
  - IDLE: reset state.
  - CALC: iterations in progress.
  - FINISH: result presented.
- ready_o = (state is IDLE or FINISH) & ~kill_i. busy_o = (state is CALC). valid_o = (state is FINISH).
- On accept:
  - Latch the operator and result sign.
  - Convert the operands to magnitudes. An operand is treated as negative only if its signed_mode bit is set and its MSB is 1.
  - Clear the 2*Width accumulator.
  - Load the iteration counter with N-1.
- Multiply: radix-2^BitsPerCycle shift-add on magnitudes. Each cycle:
  - Consume BitsPerCycle low multiplier bits.
  - Add the partial products into the accumulator.
  - Shift.
- Divide: restoring division on magnitudes. Each cycle:
  - Produce BitsPerCycle quotient bits, MSB first.
  - The partial remainder is Width+1 bits wide.
- Last CALC cycle (counter = 0): apply sign correction and write result_o.
  - MUL: low Width bits of the product; sign mode is irrelevant.
  - MULH: high Width bits of the signed product. The product is negated iff exactly one operand was treated as negative.
  - DIV: quotient, negated iff the operand signs differ.
  - REM: remainder, carrying the sign of the dividend.
- RISC-V special cases, mandatory in every mode:
  - Division by zero: DIV gives all-ones, REM gives op_a.
  - Signed overflow (most-negative / -1): DIV gives the dividend, REM gives 0.
- Early-out: if EarlyOut=1, data_ind_timing_i=0, the operator is DIV/REM and op_b_i=0 at accept, the unit goes IDLE->FINISH directly. result_o is written at accept with the divide-by-zero value.
- kill_i:
  - In any state: next state is IDLE, no valid_o, result_o is unchanged.
  - Asserted in the same cycle as en_i: the request is not accepted.
- Accept in FINISH: next state is CALC (or FINISH on early-out). The old result stays on result_o until overwritten.
- Reset in any state, including mid-CALC: state goes IDLE immediately. Outputs then read ready_o=1, busy_o=0, valid_o=0, result_o=0. The accumulator and counter clear to 0.

## Timing
- Cycle 0 is the accept cycle. CALC spans cycles 1..N. FINISH (valid_o=1) is cycle N+1. Latency from accept to valid_o is N+1.
- Early-out latency is 1 (FINISH in cycle 1).
- With data_ind_timing_i=1, latency is always N+1, whatever the operand values.
- Back-to-back issue: accept in FINISH gives a new valid_o every N+1 cycles, with no IDLE bubble.
- result_o changes only at the end of the last CALC cycle, or at an early-out accept. It is stable throughout FINISH.
- Operands, operator and data_ind_timing_i are sampled only at accept. Later input changes have no effect.
- There is no combinational path from en_i or op_* to result_o or valid_o. ready_o depends combinationally on kill_i only.

## Test plan
- Width=32, BitsPerCycle=2, signed MUL 7 * 0xFFFFFFFD -> result_o=0xFFFFFFEB, valid_o exactly in cycle 17, ready_o=1 in FINISH.
- MULH both signed 0x80000000*0x80000000 -> 0x40000000; MULHU (signed_mode=0) 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU (signed_mode=1) 0xFFFFFFFF*2 -> 0xFFFFFFFF.
- Signed DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 100/7 -> 14, REMU -> 2; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0.
- DIV 100/0 with data_ind_timing_i=0 -> 0xFFFFFFFF, valid_o in cycle 1; REM -> 100. Same with data_ind_timing_i=1 -> same values, valid_o in cycle 17.
- kill_i in cycle 5 of CALC -> no valid_o, ready_o=1 next cycle, result_o unchanged. en_i+kill_i together in IDLE -> not accepted. rst_ni low mid-CALC -> all outputs at reset values asynchronously.
- Back-to-back: 4 MULs issued on each FINISH -> valid_o pulses at cycles 17, 34, 51, 68 with correct results; sweep BitsPerCycle 1/4 -> latency 33/9.
